// File: rtl/imem_responder_if.sv
// imem_responder_if
//   Fetch-stage instruction-memory bus between a fetch unit (master) and the
//   memory responder (slave).
//
//   imem_addr   master->slave  32  read byte address
//   imem_rmask  master->slave   4  read byte mask; non-zero marks a request
//   imem_rdata  slave->master  32  read data, valid while imem_resp=1
//   imem_resp   slave->master   1  response valid, one pulse per request
//   imem_err    slave->master   1  error flag, qualified by imem_resp
interface imem_responder_if;
    logic [31:0] imem_addr;
    logic [3:0]  imem_rmask;
    logic [31:0] imem_rdata;
    logic        imem_resp;
    logic        imem_err;

    modport master (
        output imem_addr,
        output imem_rmask,
        input  imem_rdata,
        input  imem_resp,
        input  imem_err
    );

    modport slave (
        input  imem_addr,
        input  imem_rmask,
        output imem_rdata,
        output imem_resp,
        output imem_err
    );
endinterface

// File: rtl/imem_responder.sv
// imem_responder
//   Memory side of the fetch-stage I-mem bus. Holds a word-addressed program
//   image written through a loader port, accepts one read per cycle and
//   returns data in order exactly LATENCY (1..4) cycles later through a
//   shift-chain pipeline. Misaligned or out-of-range reads return FILL_WORD
//   with imem_err set.
//
//   clk          in   1   clock, rising edge
//   rst_n        in   1   asynchronous active-low reset
//   imem         slave    imem_responder_if (addr/rmask in, rdata/resp/err out)
//   load_we      in   1   loader write enable
//   load_addr    in  32   loader byte address (same mapping as reads)
//   load_wmask   in   4   loader byte-lane enables
//   load_wdata   in  32   loader write data
//
//   Optional: define IMEM_PERF_CNT_EN to add saturating counters
//   req_cnt (32), resp_cnt (32) and err_cnt (16).
module imem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h6000_0000,
    parameter int unsigned LATENCY     = 1,
    parameter logic [31:0] FILL_WORD   = 32'h0000_0013
) (
    input  logic               clk,
    input  logic               rst_n,
    imem_responder_if.slave    imem,
    input  logic               load_we,
    input  logic [31:0]        load_addr,
    input  logic [3:0]         load_wmask,
    input  logic [31:0]        load_wdata
`ifdef IMEM_PERF_CNT_EN
    ,
    output logic [31:0]        req_cnt,
    output logic [31:0]        resp_cnt,
    output logic [15:0]        err_cnt
`endif
);

    localparam int unsigned IdxW = $clog2(DEPTH_WORDS);

    logic [31:0] mem [DEPTH_WORDS];

    logic [31:0]     rd_off;
    logic [31:0]     ld_off;
    logic [IdxW-1:0] rd_idx;
    logic [IdxW-1:0] ld_idx;
    logic            rd_req;
    logic            rd_hit;
    logic            ld_hit;
    logic [31:0]     rd_data;

    // Address decode. The explicit >= BASE_ADDR test rejects addresses whose
    // offset wrapped around below the base.
    always_comb begin
        rd_off  = imem.imem_addr - BASE_ADDR;
        ld_off  = load_addr - BASE_ADDR;
        rd_idx  = rd_off[IdxW+1:2];
        ld_idx  = ld_off[IdxW+1:2];
        rd_req  = |imem.imem_rmask;
        rd_hit  = (imem.imem_addr[1:0] == 2'b00) && (imem.imem_addr >= BASE_ADDR) &&
                  ({2'b00, rd_off[31:2]} < DEPTH_WORDS);
        ld_hit  = (load_addr[1:0] == 2'b00) && (load_addr >= BASE_ADDR) &&
                  ({2'b00, ld_off[31:2]} < DEPTH_WORDS);
        rd_data = rd_hit ? mem[rd_idx] : FILL_WORD;
    end

    // Program image; not reset. Non-blocking write gives read-before-write
    // against a read sampled on the same edge.
    always_ff @(posedge clk) begin
        if (load_we && ld_hit) begin
            for (int b = 0; b < 4; b++) begin
                if (load_wmask[b]) begin
                    mem[ld_idx][8*b +: 8] <= load_wdata[8*b +: 8];
                end
            end
        end
    end

    // Response shift chain. Data registers only load when the entry feeding
    // them is valid, so the last stage holds the last returned word while idle.
    logic [LATENCY-1:0] vld_q;
    logic [LATENCY-1:0] err_q;
    logic [31:0]        data_q [LATENCY];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            err_q <= '0;
            for (int k = 0; k < LATENCY; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            vld_q[0] <= rd_req;
            err_q[0] <= rd_req & ~rd_hit;
            if (rd_req) begin
                data_q[0] <= rd_data;
            end
            for (int k = 1; k < LATENCY; k++) begin
                vld_q[k] <= vld_q[k-1];
                err_q[k] <= err_q[k-1];
                if (vld_q[k-1]) begin
                    data_q[k] <= data_q[k-1];
                end
            end
        end
    end

    assign imem.imem_rdata = data_q[LATENCY-1];
    assign imem.imem_resp  = vld_q[LATENCY-1];
    assign imem.imem_err   = vld_q[LATENCY-1] & err_q[LATENCY-1];

`ifdef IMEM_PERF_CNT_EN
    logic [31:0] req_cnt_q;
    logic [31:0] resp_cnt_q;
    logic [15:0] err_cnt_q;

    // Saturating counters: hold at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_cnt_q  <= '0;
            resp_cnt_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            if (rd_req && (req_cnt_q != '1)) begin
                req_cnt_q <= req_cnt_q + 32'd1;
            end
            if (imem.imem_resp && (resp_cnt_q != '1)) begin
                resp_cnt_q <= resp_cnt_q + 32'd1;
            end
            if (imem.imem_resp && imem.imem_err && (err_cnt_q != '1)) begin
                err_cnt_q <= err_cnt_q + 16'd1;
            end
        end
    end

    assign req_cnt  = req_cnt_q;
    assign resp_cnt = resp_cnt_q;
    assign err_cnt  = err_cnt_q;
`endif

endmodule

// File: tb/tb_imem_responder.sv
// tb_imem_responder
//   Drives identical request/load stimulus into two responders (LATENCY=1 and
//   LATENCY=3). Each request pushes the expected data, error flag and response
//   cycle onto a per-DUT queue; a negedge monitor pops and compares.
module tb_imem_responder;

    localparam int unsigned DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h6000_0000;
    localparam logic [31:0] FILL  = 32'h0000_0013;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          cyc;
    } exp_t;

    logic clk;
    logic rst_n;
    logic        load_we;
    logic [31:0] load_addr;
    logic [3:0]  load_wmask;
    logic [31:0] load_wdata;

    imem_responder_if ifa ();
    imem_responder_if ifb ();

    int   cyc;
    int   n_checks;
    int   n_errors;
    exp_t qa[$];
    exp_t qb[$];
    logic [31:0] model [DEPTH];

`ifdef IMEM_PERF_CNT_EN
    logic [31:0] req_cnt_a, resp_cnt_a, req_cnt_b, resp_cnt_b;
    logic [15:0] err_cnt_a, err_cnt_b;
`endif

    imem_responder #(
        .DEPTH_WORDS(DEPTH),
        .BASE_ADDR  (BASE),
        .LATENCY    (1),
        .FILL_WORD  (FILL)
    ) u_dut_l1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem       (ifa.slave),
        .load_we    (load_we),
        .load_addr  (load_addr),
        .load_wmask (load_wmask),
        .load_wdata (load_wdata)
`ifdef IMEM_PERF_CNT_EN
        ,
        .req_cnt    (req_cnt_a),
        .resp_cnt   (resp_cnt_a),
        .err_cnt    (err_cnt_a)
`endif
    );

    imem_responder #(
        .DEPTH_WORDS(DEPTH),
        .BASE_ADDR  (BASE),
        .LATENCY    (3),
        .FILL_WORD  (FILL)
    ) u_dut_l3 (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem       (ifb.slave),
        .load_we    (load_we),
        .load_addr  (load_addr),
        .load_wmask (load_wmask),
        .load_wdata (load_wdata)
`ifdef IMEM_PERF_CNT_EN
        ,
        .req_cnt    (req_cnt_b),
        .resp_cnt   (resp_cnt_b),
        .err_cnt    (err_cnt_b)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_read(input logic [31:0] a, output logic [31:0] d,
                                       output logic e);
        logic [31:0] off;
        off = a - BASE;
        if (a[1:0] != 2'b00 || a < BASE || off[31:2] >= DEPTH) begin
            d = FILL;
            e = 1'b1;
        end else begin
            d = model[off[11:2]];
            e = 1'b0;
        end
    endfunction

    function automatic void model_write(input logic [31:0] a, input logic [3:0] m,
                                        input logic [31:0] d);
        logic [31:0] off;
        off = a - BASE;
        if (a[1:0] == 2'b00 && a >= BASE && off[31:2] < DEPTH) begin
            for (int b = 0; b < 4; b++) begin
                if (m[b]) model[off[11:2]][8*b +: 8] = d[8*b +: 8];
            end
        end
    endfunction

    // Called at posedge+1; the request is sampled on the next edge.
    task automatic push_req(input logic [31:0] a, input logic [3:0] rm);
        logic [31:0] d;
        logic        e;
        model_read(a, d, e);
        qa.push_back('{data: d, err: e, cyc: cyc + 1});
        qb.push_back('{data: d, err: e, cyc: cyc + 3});
        ifa.imem_addr  = a;
        ifa.imem_rmask = rm;
        ifb.imem_addr  = a;
        ifb.imem_rmask = rm;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        ifa.imem_rmask = 4'h0;
        ifb.imem_rmask = 4'h0;
        load_we        = 1'b0;
    endtask

    task automatic req(input logic [31:0] a, input logic [3:0] rm);
        push_req(a, rm);
        step();
    endtask

    task automatic set_load(input logic [31:0] a, input logic [3:0] m, input logic [31:0] d);
        load_we    = 1'b1;
        load_addr  = a;
        load_wmask = m;
        load_wdata = d;
        model_write(a, m, d);
    endtask

    task automatic load(input logic [31:0] a, input logic [3:0] m, input logic [31:0] d);
        set_load(a, m, d);
        step();
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (ifa.imem_resp) begin
                if (qa.size() == 0) begin
                    check("l1_spurious_resp", 32'd1, 32'd0);
                end else begin
                    e = qa.pop_front();
                    check("l1_rdata", ifa.imem_rdata, e.data);
                    check("l1_err", 32'(ifa.imem_err), 32'(e.err));
                    check("l1_resp_cycle", 32'(cyc), 32'(e.cyc));
                end
            end else begin
                check("l1_err_idle", 32'(ifa.imem_err), 32'd0);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (ifb.imem_resp) begin
                if (qb.size() == 0) begin
                    check("l3_spurious_resp", 32'd1, 32'd0);
                end else begin
                    e = qb.pop_front();
                    check("l3_rdata", ifb.imem_rdata, e.data);
                    check("l3_err", 32'(ifb.imem_err), 32'(e.err));
                    check("l3_resp_cycle", 32'(cyc), 32'(e.cyc));
                end
            end else begin
                check("l3_err_idle", 32'(ifb.imem_err), 32'd0);
            end
        end
    end

    initial begin
        rst_n          = 1'b0;
        load_we        = 1'b0;
        load_addr      = '0;
        load_wmask     = '0;
        load_wdata     = '0;
        ifa.imem_addr  = '0;
        ifa.imem_rmask = '0;
        ifb.imem_addr  = '0;
        ifb.imem_rmask = '0;
        n_checks       = 0;
        n_errors       = 0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_l1_resp", 32'(ifa.imem_resp), 32'd0);
        check("rst_l1_err", 32'(ifa.imem_err), 32'd0);
        check("rst_l1_rdata", ifa.imem_rdata, 32'h0);
        check("rst_l3_resp", 32'(ifb.imem_resp), 32'd0);
        check("rst_l3_err", 32'(ifb.imem_err), 32'd0);
        check("rst_l3_rdata", ifb.imem_rdata, 32'h0);
        rst_n = 1'b1;
        idle(2);

        // Program image.
        load(BASE, 4'hf, 32'hDEAD_BEEF);
        load(BASE + 32'd4, 4'hf, 32'h00A0_0093);
        for (int k = 2; k < 8; k++) begin
            load(BASE + 32'(4 * k), 4'hf, 32'h1000_0000 + 32'(k));
        end
        load(BASE + 32'(4 * (DEPTH - 1)), 4'hf, 32'hCAFE_F00D);
        // Misaligned load must be ignored.
        load(BASE + 32'd5, 4'hf, 32'hFFFF_FFFF);

        // Back-to-back pair.
        req(BASE, 4'hf);
        req(BASE + 32'd4, 4'h1);
        idle(6);
        check("l1_rdata_hold", ifa.imem_rdata, 32'h00A0_0093);
        check("l3_rdata_hold", ifb.imem_rdata, 32'h00A0_0093);

        // Gaps, repeated (stalled) address, varied rmask.
        req(BASE + 32'd8, 4'h8);
        req(BASE + 32'd8, 4'h8);
        idle(1);
        req(BASE + 32'd12, 4'h3);
        req(BASE + 32'd16, 4'hf);
        idle(2);
        req(BASE + 32'd20, 4'h4);
        idle(6);

        // Error and boundary addresses.
        req(BASE + 32'd2, 4'hf);
        req(32'h5FFF_FFFC, 4'hf);
        req(BASE + 32'(4 * DEPTH), 4'hf);
        req(BASE + 32'(4 * (DEPTH - 1)), 4'hf);
        req(32'h0000_0000, 4'hf);
        req(BASE + 32'd4, 4'hf);
        idle(6);

        // Same-cycle load and read of word 0: read sees pre-write data.
        push_req(BASE, 4'hf);
        set_load(BASE, 4'b0011, 32'h1111_1111);
        step();
        req(BASE, 4'hf);
        idle(6);

        // Reset with two responses in flight on the LATENCY=3 instance.
        req(BASE + 32'd24, 4'hf);
        req(BASE + 32'd28, 4'hf);
        rst_n = 1'b0;
        #1;
        check("midrst_l1_resp", 32'(ifa.imem_resp), 32'd0);
        check("midrst_l3_resp", 32'(ifb.imem_resp), 32'd0);
        check("midrst_l3_rdata", ifb.imem_rdata, 32'h0);
        qa.delete();
        qb.delete();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(6);
        check("postrst_l3_resp", 32'(ifb.imem_resp), 32'd0);

        // Memory preserved across reset; two of five requests are errors.
        req(BASE, 4'hf);
        req(BASE + 32'd4, 4'hf);
        req(32'h5FFF_FFFC, 4'hf);
        req(BASE + 32'(4 * DEPTH), 4'hf);
        req(BASE + 32'd28, 4'hf);
        idle(6);

`ifdef IMEM_PERF_CNT_EN
        check("l1_req_cnt", req_cnt_a, 32'd5);
        check("l1_resp_cnt", resp_cnt_a, 32'd5);
        check("l1_err_cnt", 32'(err_cnt_a), 32'd2);
        check("l3_req_cnt", req_cnt_b, 32'd5);
        check("l3_resp_cnt", resp_cnt_b, 32'd5);
        check("l3_err_cnt", 32'(err_cnt_b), 32'd2);
`endif

        check("l1_queue_drained", 32'(qa.size()), 32'd0);
        check("l3_queue_drained", 32'(qb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
